imem_responder: RTL
===================

Name: imem_responder

Overview:
- Responder end of the instruction-memory read interface driven by the fetch stage. Accepts read requests (address plus read enable) with a ready/valid handshake and returns one 32-bit instruction word per accepted request after a fixed, parameterised latency.
- Backed by a word-addressed RAM with a side load port for program preload.
- Used as the imem in the processor testbench and in FPGA builds.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the RAM. Power of two, ≥ 4.
- BASE_ADDR, 32'h00000000: byte address of word 0. Must be word-aligned.
- LATENCY, 1: cycles from request acceptance to o_imem_valid. Integer ≥ 1.
- NOP_INST, 32'h00000013: word returned on a fault and the reset value of rdata (`addi x0,x0,0`).

Ports:
- i_clk  in  1  global clock
- i_rst  in  1  synchronous, active-high reset
- i_imem_raddr  in  32  byte read address of the request
- i_imem_ren  in  1  request strobe
- o_imem_ready  out  1  responder can accept a request this cycle
- o_imem_rdata  out  32  instruction word of the most recent response
- o_imem_valid  out  1  one-cycle pulse: o_imem_rdata holds a new response
- o_imem_fault  out  1  qualifies o_imem_valid: response was for a misaligned or out-of-range address
- i_load_we  in  1  preload write enable
- i_load_addr  in  32  preload byte address; bits [1:0] ignored
- i_load_data  in  32  preload word

Behaviour:
- Single clock i_clk. All state is updated on the rising edge. Reset is synchronous, active-high.
- Reset values:
  - o_imem_valid = 0, o_imem_fault = 0, o_imem_rdata = NOP_INST.
  - o_imem_ready = 0 while i_rst is high; 1 from the first cycle after release.
  - RAM contents are not cleared by reset.
- Acceptance: a request is accepted in a cycle where i_imem_ren && o_imem_ready. i_imem_raddr is sampled in that cycle. With ren low, nothing is accepted.
- Address decode:
  - idx = (raddr − BASE_ADDR) >> 2, computed modulo 2^32.
  - Fault if raddr[1:0] != 0, or raddr < BASE_ADDR, or idx ≥ DEPTH_WORDS.
  - Fault response: rdata = NOP_INST, fault = 1. The RAM is not read.
- Data capture: the RAM word, or NOP_INST on a fault, is captured at the accept edge into a holding register. The response therefore reflects RAM contents as of acceptance.
- State machine:
  - IDLE: ready = 1. On accept with LATENCY == 1, stay in IDLE and pulse valid in the next cycle. On accept with LATENCY > 1, go to WAIT and load cnt = LATENCY − 1.
  - WAIT: ready = 0. cnt decrements each cycle. When cnt reaches 0, go to RESP.
  - RESP: valid = 1 for exactly this cycle, ready = 1. A new accept here goes to WAIT with cnt reloaded; otherwise go to IDLE.
  - cnt width is $clog2(LATENCY+1).
- Throughput:
  - LATENCY = 1 is fully pipelined: one accept per cycle, valid one cycle after each accept.
  - LATENCY = L > 1: one outstanding request. Back-to-back accepts are spaced exactly L cycles apart.
- Output holding:
  - o_imem_rdata and o_imem_fault hold their last response value until the next response.
  - o_imem_fault is meaningful only while valid = 1.
- Load port:
  - A write occurs when i_load_we = 1, at any time, including during reset.
  - The address is decoded as above. Out-of-range or below-base writes are dropped silently.
  - Same word written and read-accepted in the same cycle: read-before-write. The response returns the old data; the new data is visible to accepts in later cycles.
- Reset mid-operation: any in-flight request is dropped. No valid pulse follows, and the state returns to IDLE.
- No response backpressure exists. The requester must consume the response in its valid cycle.

Test Plan:
- LATENCY=1; preload words 0..3 = 0x11,0x22,0x33,0x44; ren=1 with raddr 0,4,8,12 on consecutive cycles → valid high for 4 consecutive cycles starting one cycle after the first accept; rdata 0x11,0x22,0x33,0x44; fault=0; ready never drops.
- LATENCY=3; accept raddr 0x8 (word 0xDEADBEEF) at cycle t → ready = 0 at t+1 and t+2; valid = 1 only at t+3 with rdata 0xDEADBEEF; second request held with ren=1 is accepted at t+3; its valid arrives at t+6.
- Fault cases: raddr 0x2 → valid with fault = 1, rdata = 0x00000013. raddr = BASE_ADDR + 4*DEPTH_WORDS (0x1000 for the defaults) → same fault response. BASE_ADDR = 0x100 with raddr 0xFC → same fault response.
- Same-cycle load and read: word 5 = 0xAAAA0000; at one cycle, load_we writes 0x5555FFFF to 0x14 and a read of 0x14 is accepted → response 0xAAAA0000; the next read of 0x14 returns 0x5555FFFF.
- LATENCY=4; accept a request, then assert i_rst for one cycle at t+2 → no valid pulse ever appears; ready = 0 during reset and 1 after; rdata = 0x00000013; a new request then completes normally at accept+4.
- Idle and hold: after a response of 0x12345678, keep ren=0 for 10 cycles → valid stays 0 and rdata holds 0x12345678.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: ready/valid read port over a word-addressed RAM
// with a side preload port and a fixed, parameterised response latency.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_imem_raddr,
  input  logic        i_imem_ren,
  output logic        o_imem_ready,
  output logic [31:0] o_imem_rdata,
  output logic        o_imem_valid,
  output logic        o_imem_fault,
  input  logic        i_load_we,
  input  logic [31:0] i_load_addr,
  input  logic [31:0] i_load_data
);

  localparam int unsigned     IDX_W    = $clog2(DEPTH_WORDS);
  localparam int unsigned     CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Below-base addresses wrap when offset, so they are rejected explicitly.
  function automatic logic addr_in_range(input logic [31:0] addr);
    logic [31:0] off_v;
    off_v = addr - BASE_ADDR;
    addr_in_range = (addr >= BASE_ADDR) && ((off_v >> 2) < 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
    addr_index = IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  logic [31:0]      mem_r [DEPTH_WORDS];
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             valid_r;
  logic             valid_nxt_s;
  logic [31:0]      rdata_r;
  logic             fault_r;
  logic [31:0]      hold_data_r;
  logic             hold_fault_r;
  logic             accept_s;
  logic             rd_fault_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic [31:0]      rd_word_s;
  logic             ld_hit_s;
  logic [IDX_W-1:0] ld_idx_s;

  assign o_imem_ready = (state_r != ST_WAIT) && !i_rst;
  assign o_imem_valid = valid_r;
  assign o_imem_rdata = rdata_r;
  assign o_imem_fault = fault_r;

  // Request and preload address decode; faulting reads never touch the RAM.
  always_comb begin
    accept_s   = i_imem_ren && o_imem_ready;
    rd_fault_s = (i_imem_raddr[1:0] != 2'b00) || !addr_in_range(i_imem_raddr);
    rd_idx_s   = addr_index(i_imem_raddr);
    if (rd_fault_s) begin
      rd_word_s = NOP_INST;
    end else begin
      rd_word_s = mem_r[rd_idx_s];
    end
    ld_hit_s = i_load_we && addr_in_range(i_load_addr);
    ld_idx_s = addr_index(i_load_addr);
  end

  // Response sequencing: LATENCY==1 is a straight pipeline, otherwise IDLE/WAIT/RESP.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    valid_nxt_s = 1'b0;
    if (LATENCY == 1) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = CNT_ZERO;
      valid_nxt_s = accept_s;
    end else begin
      case (state_r)
        ST_IDLE, ST_RESP: begin
          if (accept_s) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end
        end
        ST_WAIT: begin
          if (cnt_r <= CNT_ONE) begin
            state_nxt_s = ST_RESP;
            cnt_nxt_s   = CNT_ZERO;
            valid_nxt_s = 1'b1;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Control state; reset drops any request in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Data is captured at accept so the response reflects RAM contents at that edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_data_r  <= NOP_INST;
      hold_fault_r <= 1'b0;
      rdata_r      <= NOP_INST;
      fault_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        hold_data_r  <= rd_word_s;
        hold_fault_r <= rd_fault_s;
      end
      if (LATENCY == 1) begin
        if (accept_s) begin
          rdata_r <= rd_word_s;
          fault_r <= rd_fault_s;
        end
      end else if (valid_nxt_s) begin
        rdata_r <= hold_data_r;
        fault_r <= hold_fault_r;
      end
    end
  end

  // Preload port, live during reset; the read above sees the pre-write word.
  always_ff @(posedge i_clk) begin
    if (ld_hit_s) begin
      mem_r[ld_idx_s] <= i_load_data;
    end
  end

endmodule
